dual_bank_mem_responder: RTL
============================

# dual_bank_mem_responder

Memory-side responder for the operand-fetch control unit's MAR/OE interface. Holds two 8-word × 8-bit banks: bank A holds even addresses, bank B holds odd addresses. It latches each port's MAR, returns registered read data per port, and assembles the returned words into an ordered operand pair (A = address `inst`, B = `inst+1`). It accepts both single-cycle parallel fetches and two-cycle serialized fetches. A loader-side write path through `mem_ld_*` preloads contents.

## Interface
- `DW`, 8, data width
- `AW`, 4, address width; each bank holds 2^(AW-1) words
- `clk` in 1 — system clock, all logic on rising edge
- `rst` in 1 — synchronous, active-high reset
- `mar_load_a` in 1 — load MAR A from `mar_in_a`
- `mar_in_a` in AW — address for port A; must be even
- `mem_oe_a` in 1 — read request, port A
- `mem_ld_a` in 1 — write strobe, port A
- `mem_din_a` in DW — write data, port A
- `mar_load_b`, `mar_in_b`, `mem_oe_b`, `mem_ld_b`, `mem_din_b` — same as port A; port B addresses must be odd
- `rd_data_a` / `rd_data_b` out DW — registered read data per port
- `rd_valid_a` / `rd_valid_b` out 1 — one-cycle pulse marking a valid `rd_data_*`
- `op_a`, `op_b` out DW — assembled operand pair
- `pair_valid` out 1 — one-cycle pulse marking a valid `op_a`/`op_b`
- `addr_err` out 1 — sticky: a port saw an address in the wrong bank
- `pair_err` out 1 — one-cycle pulse: protocol violation during pairing

## Operation
- **Effective address per port:**
  - If `mar_load_x` is high, the effective address is `mar_in_x`; this bypass lets the control unit load and read in the same cycle.
  - Otherwise the effective address is MAR_x.
  - MAR_x <= `mar_in_x` on `mar_load_x`.
- **Bank index and bank check:**
  - The word index is effective address[AW-1:1].
  - Setting `addr_err` requires two conditions: port A's effective address has lsb=1, or port B's has lsb=0, **and** that port asserts `mem_oe` or `mem_ld` in the same cycle.
  - On `addr_err`, the access still proceeds using the index bits.
  - `addr_err` clears only on reset.
- **Read:** on `mem_oe_x`:
  - `rd_data_x` <= bank_x[idx]
  - `rd_valid_x` <= 1
  - rd_addr_x <= effective address (internal)
- **Write:** on `mem_ld_x`, bank_x[idx] <= `mem_din_x`.
  - Read and write in the same cycle: read-before-write, so the read returns the old word.
- **Pair assembler FSM**, driven by the `rd_valid_*` pulses:
  - **IDLE, both valid:** ordering is decided by the returned addresses.
    - If (rd_addr_a+1) mod 16 == rd_addr_b, then `op_a`=`rd_data_a` and `op_b`=`rd_data_b`.
    - Else if (rd_addr_b+1) mod 16 == rd_addr_a, the order is swapped.
    - Else: pulse `pair_err`; no pair is produced.
    - On a valid pair, `pair_valid` <= 1.
  - **IDLE, one valid:** hold that word and its address as first; go to HALF.
  - **HALF, one valid:** require its address == (first+1) mod 16.
    - If so: `op_a`=first, `op_b`=new, `pair_valid` pulses.
    - Otherwise `pair_err` pulses.
    - Go to IDLE in both cases.
  - **HALF, both valid:** pulse `pair_err`, discard the held word, and treat the two new words as an IDLE-both event in the same cycle.
  - **HALF, no valid:** stay in HALF; there is no timeout.
- **Reset:**
  - `rd_data_*`, `rd_valid_*`, `op_*`, `pair_valid`, `addr_err`, `pair_err` and both MARs all go to 0.
  - The FSM goes to IDLE and any held word is dropped.
  - Bank contents are NOT cleared.
  - While `rst` is high, reads, writes and MAR loads are ignored.

## Timing
- **Read latency:** request in cycle T produces `rd_data`/`rd_valid` in cycle T+1.
- **Parallel pair:** requests in T produce `pair_valid` in T+2.
- **Serialized pair:** first request in T, second in T+1, produces `pair_valid` in T+3.
  - A second request arriving in any later cycle is also accepted.
- **Back-to-back:** full throughput, one parallel pair per cycle.
  - `pair_valid` may be high on consecutive cycles.
- **Outputs between pulses:** `op_*` hold their last values between `pair_valid` pulses. `rd_data_*` hold their last values when `rd_valid_*` is low.
- **Write visibility:** a write in T is visible to a read in T+1.

## Test plan
- **Preload and parallel read:** after reset, write addr 4 = 0x11 and addr 5 = 0x22 (port A MAR=4, port B MAR=5, `mem_ld`). Then load A=4/B=5 with `mem_oe` both -> cycle+1 `rd_data_a`=0x11, `rd_data_b`=0x22; cycle+2 `pair_valid`=1, `op_a`=0x11, `op_b`=0x22.
- **Swapped order:** preload addr 6=0x66, 7=0x77. Request B=7, A=6 parallel, with the operand starting at 7 -> `op_a`=0x77 and `op_b`=data at addr 8 is not applicable. Instead request A=0, B=15 with addr15=0xF0 and addr0=0x0F -> `op_a`=0xF0, `op_b`=0x0F (wrap).
- **Serialized:** T: load/oe A=2 (0xAA). T+1: load/oe A... use B=3 (0xBB) -> T+3 `pair_valid`, `op_a`=0xAA, `op_b`=0xBB. A gap of 3 idle cycles between the requests gives the same result.
- **Errors:**
  - A with `mar_in_a`=3 and `mem_oe_a` -> `addr_err` latches 1 and stays 1 until `rst`.
  - A=2/B=9 parallel -> `pair_err` pulses once, no `pair_valid`.
- **Read-before-write:** addr 4 = 0x11. Same cycle `mem_oe_a` + `mem_ld_a` `din`=0x55 -> read returns 0x11; the next read returns 0x55.
- **Reset mid-pair:** a single A read puts the FSM in HALF; assert `rst` one cycle; then a single B read -> no `pair_valid`, FSM in HALF again. All outputs were 0 during reset, and bank contents are preserved.

Source files
------------

// File: rtl/dual_bank_mem_responder.sv
// rtl/dual_bank_mem_responder.sv - dual-bank (even/odd) memory responder with operand pair assembler
module dual_bank_mem_responder #(
   parameter int DW = 8,
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          mar_load_a,
   input  logic [AW-1:0] mar_in_a,
   input  logic          mem_oe_a,
   input  logic          mem_ld_a,
   input  logic [DW-1:0] mem_din_a,
   input  logic          mar_load_b,
   input  logic [AW-1:0] mar_in_b,
   input  logic          mem_oe_b,
   input  logic          mem_ld_b,
   input  logic [DW-1:0] mem_din_b,
   output logic [DW-1:0] rd_data_a,
   output logic [DW-1:0] rd_data_b,
   output logic          rd_valid_a,
   output logic          rd_valid_b,
   output logic [DW-1:0] op_a,
   output logic [DW-1:0] op_b,
   output logic          pair_valid,
   output logic          addr_err,
   output logic          pair_err
);
   localparam int DEPTH = 2 ** (AW - 1);
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_HALF = 1'b1;

   logic [DW-1:0] bank_a_q [0:DEPTH-1];
   logic [DW-1:0] bank_b_q [0:DEPTH-1];

   logic [AW-1:0] mar_a_q, mar_a_d, mar_b_q, mar_b_d;
   logic [AW-1:0] eff_a, eff_b;
   logic [AW-2:0] idx_a, idx_b;
   logic [DW-1:0] rd_data_a_q, rd_data_a_d, rd_data_b_q, rd_data_b_d;
   logic          rd_valid_a_q, rd_valid_a_d, rd_valid_b_q, rd_valid_b_d;
   logic [AW-1:0] rd_addr_a_q, rd_addr_a_d, rd_addr_b_q, rd_addr_b_d;
   logic          addr_err_q, addr_err_d;
   logic [0:0]    state_q, state_d;
   logic [DW-1:0] first_data_q, first_data_d;
   logic [AW-1:0] first_addr_q, first_addr_d;
   logic [DW-1:0] op_a_q, op_a_d, op_b_q, op_b_d;
   logic          pair_valid_q, pair_valid_d, pair_err_q, pair_err_d;
   logic [DW-1:0] new_data;
   logic [AW-1:0] new_addr;

   // MAR bypass: a load and an access may share a cycle
   always_comb begin
      eff_a        = mar_load_a ? mar_in_a : mar_a_q;
      eff_b        = mar_load_b ? mar_in_b : mar_b_q;
      idx_a        = eff_a[AW-1:1];
      idx_b        = eff_b[AW-1:1];
      mar_a_d      = eff_a;
      mar_b_d      = eff_b;
      rd_data_a_d  = mem_oe_a ? bank_a_q[idx_a] : rd_data_a_q;
      rd_data_b_d  = mem_oe_b ? bank_b_q[idx_b] : rd_data_b_q;
      rd_valid_a_d = mem_oe_a;
      rd_valid_b_d = mem_oe_b;
      rd_addr_a_d  = mem_oe_a ? eff_a : rd_addr_a_q;
      rd_addr_b_d  = mem_oe_b ? eff_b : rd_addr_b_q;
      addr_err_d   = addr_err_q
                   | (eff_a[0] & (mem_oe_a | mem_ld_a))
                   | (~eff_b[0] & (mem_oe_b | mem_ld_b));
   end

   always_comb begin
      state_d      = state_q;
      first_data_d = first_data_q;
      first_addr_d = first_addr_q;
      op_a_d       = op_a_q;
      op_b_d       = op_b_q;
      pair_valid_d = 1'b0;
      pair_err_d   = 1'b0;
      new_data     = rd_valid_a_q ? rd_data_a_q : rd_data_b_q;
      new_addr     = rd_valid_a_q ? rd_addr_a_q : rd_addr_b_q;
      if (rd_valid_a_q && rd_valid_b_q) begin
         // a held half-pair is dropped when a full pair arrives
         state_d = ST_IDLE;
         if (state_q == ST_HALF) pair_err_d = 1'b1;
         if ((rd_addr_a_q + AW'(1)) == rd_addr_b_q) begin
            op_a_d       = rd_data_a_q;
            op_b_d       = rd_data_b_q;
            pair_valid_d = 1'b1;
         end else if ((rd_addr_b_q + AW'(1)) == rd_addr_a_q) begin
            op_a_d       = rd_data_b_q;
            op_b_d       = rd_data_a_q;
            pair_valid_d = 1'b1;
         end else begin
            pair_err_d = 1'b1;
         end
      end else if (rd_valid_a_q || rd_valid_b_q) begin
         if (state_q == ST_IDLE) begin
            first_data_d = new_data;
            first_addr_d = new_addr;
            state_d      = ST_HALF;
         end else begin
            state_d = ST_IDLE;
            if (new_addr == (first_addr_q + AW'(1))) begin
               op_a_d       = first_data_q;
               op_b_d       = new_data;
               pair_valid_d = 1'b1;
            end else begin
               pair_err_d = 1'b1;
            end
         end
      end
   end

   // bank contents survive reset; only the strobes are suppressed
   always_ff @(posedge clk) begin
      if (!rst && mem_ld_a) bank_a_q[idx_a] <= mem_din_a;
      if (!rst && mem_ld_b) bank_b_q[idx_b] <= mem_din_b;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mar_a_q      <= '0;
         mar_b_q      <= '0;
         rd_data_a_q  <= '0;
         rd_data_b_q  <= '0;
         rd_valid_a_q <= 1'b0;
         rd_valid_b_q <= 1'b0;
         rd_addr_a_q  <= '0;
         rd_addr_b_q  <= '0;
         addr_err_q   <= 1'b0;
         state_q      <= ST_IDLE;
         first_data_q <= '0;
         first_addr_q <= '0;
         op_a_q       <= '0;
         op_b_q       <= '0;
         pair_valid_q <= 1'b0;
         pair_err_q   <= 1'b0;
      end else begin
         mar_a_q      <= mar_a_d;
         mar_b_q      <= mar_b_d;
         rd_data_a_q  <= rd_data_a_d;
         rd_data_b_q  <= rd_data_b_d;
         rd_valid_a_q <= rd_valid_a_d;
         rd_valid_b_q <= rd_valid_b_d;
         rd_addr_a_q  <= rd_addr_a_d;
         rd_addr_b_q  <= rd_addr_b_d;
         addr_err_q   <= addr_err_d;
         state_q      <= state_d;
         first_data_q <= first_data_d;
         first_addr_q <= first_addr_d;
         op_a_q       <= op_a_d;
         op_b_q       <= op_b_d;
         pair_valid_q <= pair_valid_d;
         pair_err_q   <= pair_err_d;
      end
   end

   assign rd_data_a  = rd_data_a_q;
   assign rd_data_b  = rd_data_b_q;
   assign rd_valid_a = rd_valid_a_q;
   assign rd_valid_b = rd_valid_b_q;
   assign op_a       = op_a_q;
   assign op_b       = op_b_q;
   assign pair_valid = pair_valid_q;
   assign addr_err   = addr_err_q;
   assign pair_err   = pair_err_q;
endmodule
